// File: rtl/decoder_pkg.sv
// Shared constants and types for the scan decoder: mode encodings, default widths
// and the scan-control state.
package decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int SEL_W_DEF   = 3;
    localparam int DWELL_W_DEF = 8;

    // IDLE: idx/cnt not yet seeded for a scan; RUN: scan in progress (frozen while en=0)
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/dec_n.sv
// Combinational active-low one-cold decoder: output bit i_sel is driven low, all others high.
module dec_n #(
    parameter  int SEL_W = 3,
    localparam int N_OUT = 2**SEL_W
) (
    input  logic [SEL_W-1:0] i_sel,
    output logic [N_OUT-1:0] o_y_n
);

    always_comb begin
        o_y_n        = '1;
        o_y_n[i_sel] = 1'b0;
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered active-low decoder with DIRECT (decode sel_in) and SCAN (cycle 0..last,
// each index held dwell+1 cycles) modes; en=0 blanks outputs and freezes the scan.
module scan_decoder
    import decoder_pkg::*;
#(
    parameter  int SEL_W   = SEL_W_DEF,
    parameter  int DWELL_W = DWELL_W_DEF,
    localparam int N_OUT   = 2**SEL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel_in,
    input  logic [SEL_W-1:0]   last,
    input  logic [DWELL_W-1:0] dwell,
    output logic [N_OUT-1:0]   Y,
    output logic [SEL_W-1:0]   sel_out,
    output logic               wrap
);

    scan_state_t        r_state;
    scan_state_t        w_state_nxt;
    logic [SEL_W-1:0]   r_idx;
    logic [SEL_W-1:0]   w_idx_nxt;
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] w_cnt_nxt;
    logic               w_wrap_nxt;
    logic [SEL_W-1:0]   w_dec_sel;
    logic [N_OUT-1:0]   w_dec_y;

    // Next-state: the index chosen here is what the output registers show after the edge
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_wrap_nxt  = 1'b0;
        if (en) begin
            if (mode == MODE_DIRECT) begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
                w_cnt_nxt   = '0;
            end else if (r_state == ST_IDLE) begin
                // Entering a scan: index 0 starts with a full dwell
                w_state_nxt = ST_RUN;
                w_idx_nxt   = '0;
                w_cnt_nxt   = '0;
            end else if (r_cnt < dwell) begin
                w_cnt_nxt = r_cnt + 1'b1;
            end else begin
                w_cnt_nxt = '0;
                if (r_idx >= last) begin
                    w_idx_nxt  = '0;
                    w_wrap_nxt = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
        end
    end

    assign w_dec_sel = (mode == MODE_DIRECT) ? sel_in : w_idx_nxt;

    dec_n #(
        .SEL_W (SEL_W)
    ) u_dec (
        .i_sel (w_dec_sel),
        .o_y_n (w_dec_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Output registers: blanked while disabled, sel_out keeps the last driven index
    always_ff @(posedge clk) begin
        if (rst) begin
            Y       <= '1;
            sel_out <= '0;
            wrap    <= 1'b0;
        end else if (en) begin
            Y       <= w_dec_y;
            sel_out <= w_dec_sel;
            wrap    <= w_wrap_nxt;
        end else begin
            Y       <= '1;
            wrap    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench for scan_decoder (SEL_W=3): directed vectors push expected outputs,
// a monitor pops and compares one entry per clock edge.
module tb_scan_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       mode = 1'b1;
    logic [2:0] sel_in = '0;
    logic [2:0] last = 3'd7;
    logic [7:0] dwell = '0;
    logic [7:0] Y;
    logic [2:0] sel_out;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] y;
        logic [2:0] sel;
        logic       wrp;
        bit         chk_sel;
        string      name;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    scan_decoder #(.SEL_W(3), .DWELL_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .sel_in  (sel_in),
        .last    (last),
        .dwell   (dwell),
        .Y       (Y),
        .sel_out (sel_out),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dec8(input int k);
        logic [7:0] v;
        v = 8'h01 << k;
        return ~v;
    endfunction

    // Inputs change on the falling edge; the expectation is for the following rising edge
    task automatic step(input logic r, input logic e, input logic m, input logic [2:0] s,
                        input logic [2:0] l, input logic [7:0] d, input logic [7:0] ey,
                        input logic [2:0] es, input logic ew, input bit cs, input string nm);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; mode = m; sel_in = s; last = l; dwell = d;
        x.y = ey; x.sel = es; x.wrp = ew; x.chk_sel = cs; x.name = nm;
        sbq.push_back(x);
    endtask

    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            checks++;
            if (Y !== mon_e.y) begin
                errors++;
                $display("FAIL %s Y got %h exp %h", mon_e.name, Y, mon_e.y);
            end
            checks++;
            if (wrap !== mon_e.wrp) begin
                errors++;
                $display("FAIL %s wrap got %b exp %b", mon_e.name, wrap, mon_e.wrp);
            end
            if (mon_e.chk_sel) begin
                checks++;
                if (sel_out !== mon_e.sel) begin
                    errors++;
                    $display("FAIL %s sel_out got %0d exp %0d", mon_e.name, sel_out, mon_e.sel);
                end
            end
        end
        checks++;
        if ($countones(~Y) > 1) begin
            errors++;
            $display("FAIL onecold Y got %h exp at most one low bit", Y);
        end
    end

    logic [7:0] dir_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

    initial begin
        // Reset held three edges in SCAN, then first scan index appears
        for (int i = 0; i < 3; i++)
            step(1, 1, 1, 3'd0, 3'd7, 8'd0, 8'hFF, 3'd0, 0, 1, "reset_hold");
        step(0, 1, 1, 3'd0, 3'd7, 8'd0, 8'hFE, 3'd0, 0, 1, "reset_release");

        // DIRECT sweep
        for (int k = 0; k < 8; k++)
            step(0, 1, 0, 3'(k), 3'd7, 8'd0, dir_tab[k], 3'(k), 0, 1, "direct");

        // SCAN dwell=2 last=5: index j/3 mod 6, wrap every 18 cycles on 5->0
        for (int j = 0; j < 37; j++)
            step(0, 1, 1, 3'd0, 3'd5, 8'd2, dec8((j / 3) % 6), 3'((j / 3) % 6),
                 (j > 0) && (j % 18 == 0), 1, "scan_d2_l5");

        // SCAN->DIRECT, then SCAN dwell=0 last=7
        step(0, 1, 0, 3'd3, 3'd7, 8'd0, 8'hF7, 3'd3, 0, 1, "scan_to_direct");
        for (int j = 0; j < 17; j++)
            step(0, 1, 1, 3'd0, 3'd7, 8'd0, dec8(j % 8), 3'(j % 8),
                 (j > 0) && (j % 8 == 0), 1, "scan_d0_l7");
        for (int j = 0; j < 5; j++)
            step(0, 1, 1, 3'd0, 3'd0, 8'd0, 8'hFE, 3'd0, 1, 1, "scan_last0");

        // dwell=1 last=7, shrink last to 3 while on index 6
        step(0, 1, 0, 3'd0, 3'd7, 8'd1, 8'hFE, 3'd0, 0, 1, "direct_gap");
        for (int j = 0; j < 13; j++)
            step(0, 1, 1, 3'd0, 3'd7, 8'd1, dec8(j / 2), 3'(j / 2), 0, 1, "scan_d1_l7");
        step(0, 1, 1, 3'd0, 3'd3, 8'd1, 8'hBF, 3'd6, 0, 1, "last_shrink_hold");
        step(0, 1, 1, 3'd0, 3'd3, 8'd1, 8'hFE, 3'd0, 1, 1, "last_shrink_wrap");
        step(0, 1, 1, 3'd0, 3'd3, 8'd1, 8'hFE, 3'd0, 0, 1, "after_wrap");
        step(0, 1, 1, 3'd0, 3'd3, 8'd1, 8'hFD, 3'd1, 0, 1, "idx1_first");
        for (int j = 0; j < 4; j++)
            step(0, 0, 1, 3'd0, 3'd3, 8'd1, 8'hFF, 3'd0, 0, 0, "en_low");
        step(0, 1, 1, 3'd0, 3'd3, 8'd1, 8'hFD, 3'd1, 0, 1, "resume_frozen");
        step(0, 1, 1, 3'd0, 3'd3, 8'd1, 8'hFB, 3'd2, 0, 1, "resume_advance");

        // Reset pulsed at index 4 aborts the scan; restart from 0
        step(0, 1, 0, 3'd6, 3'd7, 8'd0, 8'hBF, 3'd6, 0, 1, "direct_gap2");
        for (int j = 0; j < 5; j++)
            step(0, 1, 1, 3'd0, 3'd7, 8'd0, dec8(j), 3'(j), 0, 1, "scan_pre_rst");
        step(1, 1, 1, 3'd0, 3'd7, 8'd0, 8'hFF, 3'd0, 0, 1, "rst_mid_scan");
        step(0, 1, 1, 3'd0, 3'd7, 8'd0, 8'hFE, 3'd0, 0, 1, "restart0");
        step(0, 1, 1, 3'd0, 3'd7, 8'd0, 8'hFD, 3'd1, 0, 1, "restart1");

        for (int i = 0; i < 5 && sbq.size() > 0; i++)
            @(posedge clk);
        @(negedge clk);
        if (sbq.size() > 0) begin
            errors++;
            $display("FAIL drain pending got %0d exp 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
